axi_stream_1_to_n_router: RTL

- Packet-level AXI Stream router with 1 input and N outputs. It is the receive-side counterpart of the N-to-1 arbiter, which prepends the source stream number to TID.
- Decodes the stream-number field in the upper TID bits of the first beat and locks that route until tlast.
- Strips the field from TID and drives the packet out of one registered output slice.
- Packets addressed to a nonexistent output are dropped and counted.

---
 rtl/axi_stream_1_to_n_router_if.sv | 53 +++++
 rtl/axi_stream_1_to_n_router.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/axi_stream_1_to_n_router_if.sv
// Signal bundle for the 1-to-N stream router: one input stream, N flattened output streams
// and the dropped-packet counter.
interface axi_stream_1_to_n_router_if #(
    parameter int AXIS_BUS_WIDTH     = 64,
    parameter int AXIS_OUT_TID_WIDTH = 1,
    parameter int AXIS_TDEST_WIDTH   = 1,
    parameter int AXIS_TUSER_WIDTH   = 1,
    parameter int NUM_OUTPUTS        = 4
);
    localparam int SEL_WIDTH         = $clog2(NUM_OUTPUTS);
    localparam int AXIS_IN_TID_WIDTH = AXIS_OUT_TID_WIDTH + SEL_WIDTH;
    localparam int KEEP_WIDTH        = AXIS_BUS_WIDTH / 8;

    logic [AXIS_BUS_WIDTH-1:0]                 axis_in_tdata;
    logic [KEEP_WIDTH-1:0]                     axis_in_tkeep;
    logic [AXIS_IN_TID_WIDTH-1:0]              axis_in_tid;
    logic [AXIS_TDEST_WIDTH-1:0]               axis_in_tdest;
    logic [AXIS_TUSER_WIDTH-1:0]               axis_in_tuser;
    logic                                      axis_in_tlast;
    logic                                      axis_in_tvalid;
    logic                                      axis_in_tready;

    logic [NUM_OUTPUTS*AXIS_BUS_WIDTH-1:0]     axis_out_tdata;
    logic [NUM_OUTPUTS*KEEP_WIDTH-1:0]         axis_out_tkeep;
    logic [NUM_OUTPUTS*AXIS_OUT_TID_WIDTH-1:0] axis_out_tid;
    logic [NUM_OUTPUTS*AXIS_TDEST_WIDTH-1:0]   axis_out_tdest;
    logic [NUM_OUTPUTS*AXIS_TUSER_WIDTH-1:0]   axis_out_tuser;
    logic [NUM_OUTPUTS-1:0]                    axis_out_tlast;
    logic [NUM_OUTPUTS-1:0]                    axis_out_tvalid;
    logic [NUM_OUTPUTS-1:0]                    axis_out_tready;

    logic [15:0]                               drop_count;

    modport master (
        output axis_in_tdata, axis_in_tkeep, axis_in_tid, axis_in_tdest,
               axis_in_tuser, axis_in_tlast, axis_in_tvalid,
        input  axis_in_tready,
        input  axis_out_tdata, axis_out_tkeep, axis_out_tid, axis_out_tdest,
               axis_out_tuser, axis_out_tlast, axis_out_tvalid,
        output axis_out_tready,
        input  drop_count
    );

    modport slave (
        input  axis_in_tdata, axis_in_tkeep, axis_in_tid, axis_in_tdest,
               axis_in_tuser, axis_in_tlast, axis_in_tvalid,
        output axis_in_tready,
        output axis_out_tdata, axis_out_tkeep, axis_out_tid, axis_out_tdest,
               axis_out_tuser, axis_out_tlast, axis_out_tvalid,
        input  axis_out_tready,
        output drop_count
    );
endinterface

// File: rtl/axi_stream_1_to_n_router.sv
// Packet router: decodes the output number from the top TID bits of a packet's first beat,
// locks the route until tlast and forwards each beat through a 1-deep slice per output.
module axi_stream_1_to_n_router #(
    parameter int AXIS_BUS_WIDTH     = 64,
    parameter int AXIS_OUT_TID_WIDTH = 1,
    parameter int AXIS_TDEST_WIDTH   = 1,
    parameter int AXIS_TUSER_WIDTH   = 1,
    parameter int NUM_OUTPUTS        = 4,
    parameter int SEL_WIDTH          = $clog2(NUM_OUTPUTS),
    parameter int AXIS_IN_TID_WIDTH  = AXIS_OUT_TID_WIDTH + SEL_WIDTH
) (
    input logic                       aclk,
    input logic                       aresetn,
    axi_stream_1_to_n_router_if.slave bus
);
    localparam int KEEP_WIDTH = AXIS_BUS_WIDTH / 8;
    localparam int SEL_SPAN   = 1 << SEL_WIDTH;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                 state_reg, state_next;
    logic [SEL_WIDTH-1:0]   route_reg, route_next;
    logic [15:0]            drop_count_reg, drop_count_next;

    logic [SEL_WIDTH-1:0]   sel_in;
    logic [SEL_WIDTH-1:0]   target_sel;
    logic [SEL_SPAN-1:0]    sel_exists;
    logic [SEL_SPAN-1:0]    slot_ready_pad;
    logic [NUM_OUTPUTS-1:0] out_tvalid;
    logic [NUM_OUTPUTS-1:0] load;
    logic                   in_ready;
    logic                   in_hs;
    logic                   forwarding;

    assign sel_in = bus.axis_in_tid[AXIS_IN_TID_WIDTH-1 -: SEL_WIDTH];

    // Selector codes beyond NUM_OUTPUTS map to padding entries that mark the packet for dropping.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_SPAN; gi++) begin : g_sel
            if (gi < NUM_OUTPUTS) begin : g_real
                assign sel_exists[gi]     = 1'b1;
                assign slot_ready_pad[gi] = !out_tvalid[gi] || bus.axis_out_tready[gi];
            end else begin : g_pad
                assign sel_exists[gi]     = 1'b0;
                assign slot_ready_pad[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= IDLE;
            route_reg      <= '0;
            drop_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            route_reg      <= route_next;
            drop_count_reg <= drop_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        route_next      = route_reg;
        drop_count_next = drop_count_reg;
        target_sel      = route_reg;
        forwarding      = 1'b0;
        in_ready        = 1'b0;
        case (state_reg)
            IDLE: begin
                // Header beat: route comes from the live TID, ready only if that slice has room.
                target_sel = sel_in;
                forwarding = sel_exists[sel_in];
                in_ready   = forwarding ? slot_ready_pad[sel_in] : 1'b1;
            end
            FWD: begin
                forwarding = 1'b1;
                in_ready   = slot_ready_pad[route_reg];
            end
            DROP: begin
                in_ready = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
        in_ready = in_ready && aresetn;
        in_hs    = bus.axis_in_tvalid && in_ready;
        if (in_hs) begin
            case (state_reg)
                IDLE: begin
                    if (forwarding) begin
                        route_next = sel_in;
                        state_next = bus.axis_in_tlast ? IDLE : FWD;
                    end else begin
                        if (drop_count_reg != 16'hFFFF) begin
                            drop_count_next = drop_count_reg + 16'd1;
                        end
                        state_next = bus.axis_in_tlast ? IDLE : DROP;
                    end
                end
                FWD, DROP: begin
                    if (bus.axis_in_tlast) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.axis_in_tready = in_ready;
    assign bus.drop_count     = drop_count_reg;

    generate
        for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_slice
            logic                          tvalid_reg;
            logic                          tlast_reg;
            logic [AXIS_BUS_WIDTH-1:0]     tdata_reg;
            logic [KEEP_WIDTH-1:0]         tkeep_reg;
            logic [AXIS_OUT_TID_WIDTH-1:0] tid_reg;
            logic [AXIS_TDEST_WIDTH-1:0]   tdest_reg;
            logic [AXIS_TUSER_WIDTH-1:0]   tuser_reg;

            assign load[gi] = in_hs && forwarding && (target_sel == SEL_WIDTH'(gi));

            // A load in the same cycle as an output handshake replaces the beat and keeps tvalid high.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    tvalid_reg <= 1'b0;
                    tlast_reg  <= 1'b0;
                    tdata_reg  <= '0;
                    tkeep_reg  <= '0;
                    tid_reg    <= '0;
                    tdest_reg  <= '0;
                    tuser_reg  <= '0;
                end else if (load[gi]) begin
                    tvalid_reg <= 1'b1;
                    tlast_reg  <= bus.axis_in_tlast;
                    tdata_reg  <= bus.axis_in_tdata;
                    tkeep_reg  <= bus.axis_in_tkeep;
                    tid_reg    <= bus.axis_in_tid[AXIS_OUT_TID_WIDTH-1:0];
                    tdest_reg  <= bus.axis_in_tdest;
                    tuser_reg  <= bus.axis_in_tuser;
                end else if (bus.axis_out_tready[gi]) begin
                    tvalid_reg <= 1'b0;
                end
            end

            assign out_tvalid[gi]                                             = tvalid_reg;
            assign bus.axis_out_tvalid[gi]                                    = tvalid_reg;
            assign bus.axis_out_tlast[gi]                                     = tlast_reg;
            assign bus.axis_out_tdata[gi*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH]    = tdata_reg;
            assign bus.axis_out_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH]            = tkeep_reg;
            assign bus.axis_out_tid[gi*AXIS_OUT_TID_WIDTH +: AXIS_OUT_TID_WIDTH] = tid_reg;
            assign bus.axis_out_tdest[gi*AXIS_TDEST_WIDTH +: AXIS_TDEST_WIDTH] = tdest_reg;
            assign bus.axis_out_tuser[gi*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH] = tuser_reg;
        end
    endgenerate
endmodule
